// File: rtl/bomb_pkg.sv
// Shared types and counter widths for the bomb game sequencer.
// Imported by bomb_round_ctrl and its testbench.
package bomb_pkg;

  localparam int SEC_W   = 6;
  localparam int LIVES_W = 3;
  localparam int ROUND_W = 4;
  localparam int FACE_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_PLAY,
    S_WIN,
    S_LOSE,
    S_DONE
  } state_t;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1, tick on the wrap cycle.
// Ports: clk, rst_n (async low), clr (sync clear), tick (wrap strobe).
module sec_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bomb_round_ctrl.sv
// Multi-round bomb game sequencer: arm, show password, countdown, entry, face.
// Ports: arm/load/submit/sw_in/rand_num in; psw, status, faces, pulses out.
module bomb_round_ctrl
  import bomb_pkg::*;
#(
  parameter int PSW_W     = 7,
  parameter int CNT_SEC   = 20,
  parameter int SHOW_SEC  = 3,
  parameter int TICK_DIV  = 50000000,
  parameter int MAX_LIVES = 3,
  parameter int ROUNDS    = 3,
  parameter int FACE_SEC  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               load,
  input  logic               submit,
  input  logic [PSW_W-1:0]   sw_in,
  input  logic [PSW_W-1:0]   rand_num,
  output logic [PSW_W-1:0]   psw,
  output logic               showing,
  output logic               input_en,
  output logic               bomb_on,
  output logic [SEC_W-1:0]   sec_left,
  output logic [LIVES_W-1:0] lives,
  output logic [ROUND_W-1:0] round_num,
  output logic               win_face,
  output logic               lose_face,
  output logic               beep_en,
  output logic               success,
  output logic               fail
);

  localparam logic [SEC_W-1:0]   SEC_CNT  = SEC_W'(CNT_SEC);
  localparam logic [SEC_W-1:0]   SEC_SHOW = SEC_W'(SHOW_SEC);
  localparam logic [SEC_W-1:0]   SEC_ONE  = SEC_W'(1);
  localparam logic [LIVES_W-1:0] LIV_MAX  = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] LIV_ONE  = LIVES_W'(1);
  localparam logic [ROUND_W-1:0] RND_ONE  = ROUND_W'(1);
  localparam logic [ROUND_W-1:0] RND_LAST = ROUND_W'(ROUNDS);
  localparam logic [FACE_W-1:0]  FACE_LEN = FACE_W'(FACE_SEC);
  localparam logic [FACE_W-1:0]  FACE_ONE = FACE_W'(1);

  state_t            state;
  logic [FACE_W-1:0] face_cnt;
  logic              won;
  logic              tick;
  logic              clr;
  logic              match;
  logic              sec_end;

  assign match   = (sw_in == psw);
  assign sec_end = (sec_left == SEC_ONE);

  // Prescaler restarts whenever the FSM is about to change state,
  // so every state sees its first tick a full second after entry.
  always_comb begin
    clr = 1'b0;
    if (!arm) begin
      clr = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: clr = load;
        S_SHOW:         clr = tick && sec_end;
        S_PLAY:         clr = (submit && (match || lives <= LIV_ONE))
                              || (tick && sec_end);
        S_WIN, S_LOSE:  clr = tick && (face_cnt == FACE_ONE);
        default:        clr = 1'b1;
      endcase
    end
  end

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      psw       <= '0;
      sec_left  <= SEC_CNT;
      lives     <= LIV_MAX;
      round_num <= RND_ONE;
      face_cnt  <= '0;
      won       <= 1'b0;
      success   <= 1'b0;
      fail      <= 1'b0;
    end else begin
      success <= 1'b0;
      fail    <= 1'b0;
      if (!arm) begin
        // psw deliberately keeps its value across an abort
        state     <= S_IDLE;
        sec_left  <= SEC_CNT;
        lives     <= LIV_MAX;
        round_num <= RND_ONE;
        face_cnt  <= '0;
        won       <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (load) begin
              psw       <= rand_num;
              round_num <= RND_ONE;
              lives     <= LIV_MAX;
              sec_left  <= SEC_SHOW;
              won       <= 1'b0;
              state     <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (tick) begin
              if (sec_end) begin
                sec_left <= SEC_CNT;
                state    <= S_PLAY;
              end else begin
                sec_left <= sec_left - SEC_ONE;
              end
            end
          end
          S_PLAY: begin
            if (submit && match) begin
              success  <= 1'b1;
              won      <= 1'b1;
              face_cnt <= FACE_LEN;
              state    <= S_WIN;
            end else if (submit && lives <= LIV_ONE) begin
              lives    <= '0;
              fail     <= 1'b1;
              face_cnt <= FACE_LEN;
              state    <= S_LOSE;
            end else begin
              // a survivable miss does not stall the countdown
              if (submit) begin
                lives <= lives - LIV_ONE;
              end
              if (tick) begin
                if (sec_end) begin
                  sec_left <= '0;
                  fail     <= 1'b1;
                  face_cnt <= FACE_LEN;
                  state    <= S_LOSE;
                end else begin
                  sec_left <= sec_left - SEC_ONE;
                end
              end
            end
          end
          S_WIN: begin
            if (tick) begin
              if (face_cnt == FACE_ONE) begin
                if (round_num < RND_LAST) begin
                  round_num <= round_num + RND_ONE;
                  psw       <= rand_num;
                  lives     <= LIV_MAX;
                  sec_left  <= SEC_SHOW;
                  state     <= S_SHOW;
                end else begin
                  state <= S_DONE;
                end
              end else begin
                face_cnt <= face_cnt - FACE_ONE;
              end
            end
          end
          S_LOSE: begin
            if (tick) begin
              if (face_cnt == FACE_ONE) begin
                state <= S_DONE;
              end else begin
                face_cnt <= face_cnt - FACE_ONE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Outputs decode the registered state; won picks the final face.
  assign showing   = (state == S_SHOW);
  assign input_en  = (state == S_PLAY);
  assign bomb_on   = (state == S_SHOW) || (state == S_PLAY);
  assign win_face  = (state == S_WIN) || ((state == S_DONE) && won);
  assign lose_face = (state == S_LOSE) || ((state == S_DONE) && !won);
  assign beep_en   = (state == S_WIN) || (state == S_LOSE);

endmodule
